// File: rtl/instr_decode_buf_pkg.sv
// decoder_pkg: shared field layout for the instruction decode buffer.
//   DEF_* localparams   default widths; instr_decode_buf takes its defaults from these
//   *_LSB / IMM_WIDTH   bit offsets of each field in the default instruction word
//   dec_fields_t        instruction word viewed as fields (MSB-first, so a
//                       plain cast of a word lines up with the bit layout)
//   sign_ext()          sign-extends the low 'width' bits of a value to SX_W bits
package decoder_pkg;

    localparam int DEF_BUS_WIDTH    = 33;
    localparam int DEF_OPCODE_WIDTH = 5;
    localparam int DEF_ADDR_WIDTH   = 5;

    localparam int RD_LSB    = DEF_OPCODE_WIDTH;
    localparam int RS_LSB    = RD_LSB + DEF_ADDR_WIDTH;
    localparam int SEL_BIT   = RS_LSB + DEF_ADDR_WIDTH;
    localparam int IMM_LSB   = SEL_BIT + 1;
    localparam int IMM_WIDTH = DEF_BUS_WIDTH - IMM_LSB;

    // Working width of sign_ext(); callers cast the result down to their bus.
    localparam int SX_W = 64;

    typedef struct packed {
        logic [IMM_WIDTH-1:0]        imm;
        logic                        sel;
        logic [DEF_ADDR_WIDTH-1:0]   rs;
        logic [DEF_ADDR_WIDTH-1:0]   rd;
        logic [DEF_OPCODE_WIDTH-1:0] opcode;
    } dec_fields_t;

    function automatic logic [SX_W-1:0] sign_ext(input logic [SX_W-1:0] raw,
                                                 input int              width);
        logic [SX_W-1:0] res;
        for (int i = 0; i < SX_W; i++) begin
            res[i] = (i < width) ? raw[i] : raw[width-1];
        end
        return res;
    endfunction

endpackage

// File: rtl/instr_decode_buf_if.sv
// instr_decode_buf_if: fetch-side, execute-side and retire signals of the decoder.
//   fetch:   instr_valid, instr, instr_ready, flush
//   issue:   dec_valid, dec_ready, opcode, rd_addr, rs_addr, rs_addr_sel,
//            rs_addr_valid, imme_value
//   retire:  op_done_valid, op_done_addr, err_done
// Modports: master = fetch/execute environment, slave = the decoder.
interface instr_decode_buf_if
    import decoder_pkg::*;
#(
    parameter int BUS_WIDTH    = DEF_BUS_WIDTH,
    parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH
) ();
    logic                    instr_valid;
    logic [BUS_WIDTH-1:0]    instr;
    logic                    instr_ready;
    logic                    flush;
    logic                    dec_valid;
    logic                    dec_ready;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [ADDR_WIDTH-1:0]   rs_addr;
    logic                    rs_addr_sel;
    logic                    rs_addr_valid;
    logic [BUS_WIDTH-1:0]    imme_value;
    logic                    op_done_valid;
    logic [ADDR_WIDTH-1:0]   op_done_addr;
    logic                    err_done;

    modport master (
        output instr_valid, instr, flush, dec_ready, op_done_valid, op_done_addr,
        input  instr_ready, dec_valid, opcode, rd_addr, rs_addr, rs_addr_sel,
               rs_addr_valid, imme_value, err_done
    );

    modport slave (
        input  instr_valid, instr, flush, dec_ready, op_done_valid, op_done_addr,
        output instr_ready, dec_valid, opcode, rd_addr, rs_addr, rs_addr_sel,
               rs_addr_valid, imme_value, err_done
    );
endinterface

// File: rtl/instr_decode_buf_fifo.sv
// instr_fifo: synchronous FIFO with occupancy counter.
//   push/pop   requests; qualified internally by !full / !empty
//   flush      empties the FIFO on the next edge, overriding push and pop
//   din/head   write data / current head word (storage resets to 0)
//   full/empty occupancy flags
module instr_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/instr_decode_buf.sv
// instr_decode_buf: buffered instruction decoder with register scoreboard.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         instr_decode_buf_if.slave: fetch handshake in, decoded issue
//               handshake out, retire notifications in, sticky err_done out
// The head of the FIFO is decoded combinationally. Issue is held back while the
// head's rd (WAW) or register rs (RAW) is busy, or MAX_OUTSTANDING ops are in flight.
module instr_decode_buf
    import decoder_pkg::*;
#(
    parameter int BUS_WIDTH       = DEF_BUS_WIDTH,
    parameter int OPCODE_WIDTH    = DEF_OPCODE_WIDTH,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input logic               clk,
    input logic               rst_n,
    instr_decode_buf_if.slave bus
);
    localparam int F_RD_LSB  = OPCODE_WIDTH;
    localparam int F_RS_LSB  = F_RD_LSB + ADDR_WIDTH;
    localparam int F_SEL     = F_RS_LSB + ADDR_WIDTH;
    localparam int F_IMM_LSB = F_SEL + 1;
    localparam int F_IMM_W   = BUS_WIDTH - F_IMM_LSB;
    localparam int CNT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam int NREG      = 2 ** ADDR_WIDTH;

    logic [BUS_WIDTH-1:0]    head;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [ADDR_WIDTH-1:0]   rd;
    logic [ADDR_WIDTH-1:0]   rs;
    logic                    sel;
    logic [F_IMM_W-1:0]      imm_raw;
    logic                    can_issue;
    logic                    issue;
    logic                    retire_bad;
    logic                    retire_ok;
    logic [NREG-1:0]         busy;
    logic [NREG-1:0]         busy_nxt;
    logic [CNT_W-1:0]        count_out;
    logic [CNT_W-1:0]        count_nxt;
    logic                    err_done;

    instr_fifo #(.WIDTH(BUS_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.instr_valid),
        .pop   (issue),
        .flush (bus.flush),
        .din   (bus.instr),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign opcode  = head[OPCODE_WIDTH-1:0];
    assign rd      = head[F_RS_LSB-1:F_RD_LSB];
    assign rs      = head[F_SEL-1:F_RS_LSB];
    assign sel     = head[F_SEL];
    assign imm_raw = head[BUS_WIDTH-1:F_IMM_LSB];

    // rs only matters as a hazard when it names a register (sel == 0).
    assign can_issue = !fifo_empty
                       && (count_out < CNT_W'(MAX_OUTSTANDING))
                       && !busy[rd]
                       && !(!sel && busy[rs]);
    assign issue     = can_issue && bus.dec_ready;

    // A retire with nothing outstanding, or naming a non-busy register, is a
    // protocol error and must not disturb the count or scoreboard.
    assign retire_bad = bus.op_done_valid
                        && ((count_out == '0)
                            || ((bus.op_done_addr != '0) && !busy[bus.op_done_addr]));
    assign retire_ok  = bus.op_done_valid && !retire_bad;

    always_comb begin
        count_nxt = count_out;
        busy_nxt  = busy;
        case ({issue, retire_ok})
            2'b10:   count_nxt = count_out + CNT_W'(1);
            2'b01:   count_nxt = count_out - CNT_W'(1);
            default: count_nxt = count_out;
        endcase
        // Clear before set so a same-cycle issue to the retiring rd stays busy.
        if (retire_ok) busy_nxt[bus.op_done_addr] = 1'b0;
        if (issue && (rd != '0)) busy_nxt[rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_out <= '0;
            busy      <= '0;
            err_done  <= 1'b0;
        end else begin
            count_out <= count_nxt;
            busy      <= busy_nxt;
            err_done  <= err_done | retire_bad;
        end
    end

    assign bus.instr_ready   = !fifo_full;
    assign bus.dec_valid     = can_issue;
    assign bus.opcode        = opcode;
    assign bus.rd_addr       = rd;
    assign bus.rs_addr       = rs;
    assign bus.rs_addr_sel   = sel;
    assign bus.rs_addr_valid = !sel;
    assign bus.imme_value    = BUS_WIDTH'(sign_ext(SX_W'(imm_raw), F_IMM_W));
    assign bus.err_done      = err_done;
endmodule

// File: tb/tb_instr_decode_buf.sv
module tb_instr_decode_buf;
    import decoder_pkg::*;

    logic clk;
    logic rst_n;
    int   vecs;
    int   errs;

    instr_decode_buf_if bus ();

    instr_decode_buf dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] mk(input logic [4:0] opc, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic sel,
                                       input logic [16:0] imm);
        dec_fields_t f;
        f.opcode = opc;
        f.rd     = rd;
        f.rs     = rs;
        f.sel    = sel;
        f.imm    = imm;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [4:0] addr);
        bus.op_done_valid = 1'b1;
        bus.op_done_addr  = addr;
        tick();
        bus.op_done_valid = 1'b0;
        bus.op_done_addr  = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.instr_valid = 1'b0; bus.instr = '0; bus.flush = 1'b0;
        bus.dec_ready = 1'b0; bus.op_done_valid = 1'b0; bus.op_done_addr = '0;
        #12;
        vecs++; if (bus.instr_ready !== 1'b1) begin errs++; $display("FAIL reset_instr_ready got=%b exp=1", bus.instr_ready); end
        vecs++; if (bus.dec_valid !== 1'b0) begin errs++; $display("FAIL reset_dec_valid got=%b exp=0", bus.dec_valid); end
        vecs++; if (bus.opcode !== 5'd0 || bus.rd_addr !== 5'd0 || bus.rs_addr !== 5'd0 || bus.rs_addr_sel !== 1'b0)
            begin errs++; $display("FAIL reset_fields got=%h/%h/%h/%b exp=0/0/0/0", bus.opcode, bus.rd_addr, bus.rs_addr, bus.rs_addr_sel); end
        vecs++; if (bus.imme_value !== 33'h0) begin errs++; $display("FAIL reset_imm got=%h exp=0", bus.imme_value); end
        vecs++; if (bus.rs_addr_valid !== 1'b1) begin errs++; $display("FAIL reset_rs_valid got=%b exp=1", bus.rs_addr_valid); end
        vecs++; if (bus.err_done !== 1'b0) begin errs++; $display("FAIL reset_err got=%b exp=0", bus.err_done); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_decode();
        bus.instr_valid = 1'b1;
        bus.instr = 33'h0_0000_1C22;
        vecs++; if (bus.dec_valid !== 1'b0) begin errs++; $display("FAIL basic_no_bypass got=%b exp=0", bus.dec_valid); end
        tick();
        bus.instr_valid = 1'b0;
        vecs++; if (bus.dec_valid !== 1'b1) begin errs++; $display("FAIL basic_valid got=%b exp=1", bus.dec_valid); end
        vecs++; if (bus.opcode !== 5'd2 || bus.rd_addr !== 5'd1 || bus.rs_addr !== 5'd7)
            begin errs++; $display("FAIL basic_fields got=%0d/%0d/%0d exp=2/1/7", bus.opcode, bus.rd_addr, bus.rs_addr); end
        vecs++; if (bus.rs_addr_valid !== 1'b1 || bus.rs_addr_sel !== 1'b0)
            begin errs++; $display("FAIL basic_sel got=%b/%b exp=1/0", bus.rs_addr_valid, bus.rs_addr_sel); end
        vecs++; if (bus.imme_value !== 33'h0) begin errs++; $display("FAIL basic_imm got=%h exp=0", bus.imme_value); end
        bus.dec_ready = 1'b1;
        tick();
        bus.dec_ready = 1'b0;
        vecs++; if (bus.dec_valid !== 1'b0) begin errs++; $display("FAIL basic_popped got=%b exp=0", bus.dec_valid); end
        retire(5'd1);
        vecs++; if (bus.err_done !== 1'b0) begin errs++; $display("FAIL basic_retire_err got=%b exp=0", bus.err_done); end
    endtask

    task automatic test_immediate();
        bus.instr_valid = 1'b1;
        bus.instr = mk(5'd4, 5'd0, 5'd9, 1'b1, 17'h1FFFF);
        tick();
        vecs++; if (bus.imme_value !== 33'h1_FFFF_FFFF) begin errs++; $display("FAIL imm_neg got=%h exp=1ffffffff", bus.imme_value); end
        vecs++; if (bus.rs_addr_sel !== 1'b1 || bus.rs_addr_valid !== 1'b0)
            begin errs++; $display("FAIL imm_sel got=%b/%b exp=1/0", bus.rs_addr_sel, bus.rs_addr_valid); end
        bus.instr = mk(5'd5, 5'd0, 5'd0, 1'b0, 17'h0ABCD);
        bus.dec_ready = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        bus.dec_ready = 1'b0;
        vecs++; if (bus.imme_value !== 33'h0_0000_ABCD) begin errs++; $display("FAIL imm_pos got=%h exp=0000abcd", bus.imme_value); end
        vecs++; if (bus.dec_valid !== 1'b1 || bus.opcode !== 5'd5)
            begin errs++; $display("FAIL imm_second got=%b/%0d exp=1/5", bus.dec_valid, bus.opcode); end
        // issue and retire in the same edge: outstanding stays at 1
        bus.dec_ready = 1'b1;
        retire(5'd0);
        bus.dec_ready = 1'b0;
        retire(5'd0);
        vecs++; if (bus.err_done !== 1'b0) begin errs++; $display("FAIL imm_count_kept got=%b exp=0", bus.err_done); end
    endtask

    task automatic test_full();
        logic [4:0] exp_op;
        bus.dec_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.instr_valid = 1'b1;
            bus.instr = mk(5'(k + 1), 5'd0, 5'd0, 1'b0, 17'h0);
            vecs++; if (bus.instr_ready !== 1'b1) begin errs++; $display("FAIL full_ready_%0d got=%b exp=1", k, bus.instr_ready); end
            tick();
        end
        vecs++; if (bus.instr_ready !== 1'b0) begin errs++; $display("FAIL full_after4 got=%b exp=0", bus.instr_ready); end
        bus.instr = mk(5'd5, 5'd0, 5'd0, 1'b0, 17'h0);
        tick();
        vecs++; if (bus.instr_ready !== 1'b0 || bus.opcode !== 5'd1)
            begin errs++; $display("FAIL full_hold got=%b/%0d exp=0/1", bus.instr_ready, bus.opcode); end
        bus.dec_ready = 1'b1;
        tick();
        bus.dec_ready = 1'b0;
        vecs++; if (bus.instr_ready !== 1'b1 || bus.opcode !== 5'd2)
            begin errs++; $display("FAIL full_pop_no_push got=%b/%0d exp=1/2", bus.instr_ready, bus.opcode); end
        tick();
        bus.instr_valid = 1'b0;
        vecs++; if (bus.instr_ready !== 1'b0) begin errs++; $display("FAIL full_fifth_in got=%b exp=0", bus.instr_ready); end
        retire(5'd0);
        for (int k = 0; k < 4; k++) begin
            exp_op = 5'(k + 2);
            vecs++; if (bus.dec_valid !== 1'b1 || bus.opcode !== exp_op)
                begin errs++; $display("FAIL full_drain_%0d got=%b/%0d exp=1/%0d", k, bus.dec_valid, bus.opcode, exp_op); end
            bus.dec_ready = 1'b1;
            tick();
            bus.dec_ready = 1'b0;
            retire(5'd0);
        end
        vecs++; if (bus.dec_valid !== 1'b0 || bus.instr_ready !== 1'b1 || bus.err_done !== 1'b0)
            begin errs++; $display("FAIL full_drained got=%b/%b/%b exp=0/1/0", bus.dec_valid, bus.instr_ready, bus.err_done); end
    endtask

    task automatic test_hazards();
        bus.instr_valid = 1'b1;
        bus.instr = mk(5'd6, 5'd3, 5'd0, 1'b0, 17'h0);
        tick();
        bus.instr = mk(5'd7, 5'd4, 5'd3, 1'b0, 17'h0);
        tick();
        bus.instr_valid = 1'b0;
        vecs++; if (bus.dec_valid !== 1'b1 || bus.opcode !== 5'd6)
            begin errs++; $display("FAIL raw_first got=%b/%0d exp=1/6", bus.dec_valid, bus.opcode); end
        bus.dec_ready = 1'b1;
        tick();
        vecs++; if (bus.dec_valid !== 1'b0 || bus.opcode !== 5'd7)
            begin errs++; $display("FAIL raw_stall got=%b/%0d exp=0/7", bus.dec_valid, bus.opcode); end
        tick();
        vecs++; if (bus.dec_valid !== 1'b0) begin errs++; $display("FAIL raw_stall2 got=%b exp=0", bus.dec_valid); end
        bus.op_done_valid = 1'b1;
        bus.op_done_addr = 5'd3;
        #1;
        vecs++; if (bus.dec_valid !== 1'b0) begin errs++; $display("FAIL raw_no_forward got=%b exp=0", bus.dec_valid); end
        tick();
        bus.op_done_valid = 1'b0;
        vecs++; if (bus.dec_valid !== 1'b1) begin errs++; $display("FAIL raw_release got=%b exp=1", bus.dec_valid); end
        tick();
        bus.dec_ready = 1'b0;
        retire(5'd4);
        // WAW on rd=5
        bus.instr_valid = 1'b1;
        bus.instr = mk(5'd8, 5'd5, 5'd0, 1'b0, 17'h0);
        tick();
        bus.instr = mk(5'd9, 5'd5, 5'd0, 1'b0, 17'h0);
        tick();
        bus.instr_valid = 1'b0;
        bus.dec_ready = 1'b1;
        tick();
        vecs++; if (bus.dec_valid !== 1'b0 || bus.opcode !== 5'd9)
            begin errs++; $display("FAIL waw_stall got=%b/%0d exp=0/9", bus.dec_valid, bus.opcode); end
        retire(5'd5);
        vecs++; if (bus.dec_valid !== 1'b1) begin errs++; $display("FAIL waw_release got=%b exp=1", bus.dec_valid); end
        tick();
        bus.dec_ready = 1'b0;
        retire(5'd5);
        vecs++; if (bus.err_done !== 1'b0) begin errs++; $display("FAIL hazard_err got=%b exp=0", bus.err_done); end
    endtask

    task automatic test_outstanding();
        for (int k = 0; k < 4; k++) begin
            bus.instr_valid = 1'b1;
            bus.instr = mk(5'(10 + k), 5'd0, 5'd0, 1'b0, 17'h0);
            tick();
        end
        bus.instr_valid = 1'b0;
        bus.dec_ready = 1'b1;
        tick();
        tick();
        vecs++; if (bus.dec_valid !== 1'b0 || bus.opcode !== 5'd12)
            begin errs++; $display("FAIL max_stall got=%b/%0d exp=0/12", bus.dec_valid, bus.opcode); end
        tick();
        vecs++; if (bus.dec_valid !== 1'b0) begin errs++; $display("FAIL max_stall2 got=%b exp=0", bus.dec_valid); end
        retire(5'd0);
        vecs++; if (bus.dec_valid !== 1'b1 || bus.opcode !== 5'd12)
            begin errs++; $display("FAIL max_release got=%b/%0d exp=1/12", bus.dec_valid, bus.opcode); end
        retire(5'd0);
        vecs++; if (bus.dec_valid !== 1'b1 || bus.opcode !== 5'd13)
            begin errs++; $display("FAIL max_issue_retire got=%b/%0d exp=1/13", bus.dec_valid, bus.opcode); end
        bus.instr_valid = 1'b1;
        bus.instr = mk(5'd14, 5'd0, 5'd0, 1'b0, 17'h0);
        tick();
        bus.instr_valid = 1'b0;
        bus.dec_ready = 1'b0;
        vecs++; if (bus.dec_valid !== 1'b0 || bus.opcode !== 5'd14)
            begin errs++; $display("FAIL max_at_limit got=%b/%0d exp=0/14", bus.dec_valid, bus.opcode); end
        retire(5'd0);
        retire(5'd0);
        vecs++; if (bus.dec_valid !== 1'b1 || bus.err_done !== 1'b0)
            begin errs++; $display("FAIL max_drained got=%b/%b exp=1/0", bus.dec_valid, bus.err_done); end
    endtask

    task automatic test_err_flush();
        retire(5'd0);
        vecs++; if (bus.err_done !== 1'b1) begin errs++; $display("FAIL err_set got=%b exp=1", bus.err_done); end
        bus.instr_valid = 1'b1;
        bus.instr = mk(5'd15, 5'd0, 5'd0, 1'b0, 17'h0);
        tick();
        bus.instr = mk(5'd16, 5'd0, 5'd0, 1'b0, 17'h0);
        tick();
        bus.instr_valid = 1'b0;
        vecs++; if (bus.dec_valid !== 1'b1 || bus.instr_ready !== 1'b1 || bus.err_done !== 1'b1)
            begin errs++; $display("FAIL err_sticky got=%b/%b/%b exp=1/1/1", bus.dec_valid, bus.instr_ready, bus.err_done); end
        bus.flush = 1'b1;
        bus.instr_valid = 1'b1;
        bus.instr = mk(5'd17, 5'd0, 5'd0, 1'b0, 17'h0);
        tick();
        bus.flush = 1'b0;
        bus.instr_valid = 1'b0;
        vecs++; if (bus.dec_valid !== 1'b0 || bus.instr_ready !== 1'b1)
            begin errs++; $display("FAIL flush_empty got=%b/%b exp=0/1", bus.dec_valid, bus.instr_ready); end
        bus.instr_valid = 1'b1;
        bus.instr = mk(5'd18, 5'd0, 5'd0, 1'b0, 17'h0);
        tick();
        vecs++; if (bus.dec_valid !== 1'b1 || bus.opcode !== 5'd18)
            begin errs++; $display("FAIL flush_refill got=%b/%0d exp=1/18", bus.dec_valid, bus.opcode); end
        for (int k = 0; k < 3; k++) begin
            bus.instr = mk(5'(19 + k), 5'd0, 5'd0, 1'b0, 17'h0);
            tick();
        end
        bus.instr_valid = 1'b0;
        vecs++; if (bus.instr_ready !== 1'b0 || bus.err_done !== 1'b1)
            begin errs++; $display("FAIL flush_count got=%b/%b exp=0/1", bus.instr_ready, bus.err_done); end
    endtask

    task automatic test_async_reset();
        rst_n = 1'b0;
        #2;
        vecs++; if (bus.instr_ready !== 1'b1 || bus.dec_valid !== 1'b0 || bus.err_done !== 1'b0 || bus.opcode !== 5'd0)
            begin errs++; $display("FAIL async_reset got=%b/%b/%b/%0d exp=1/0/0/0", bus.instr_ready, bus.dec_valid, bus.err_done, bus.opcode); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_basic_decode();
        test_immediate();
        test_full();
        test_hazards();
        test_outstanding();
        test_err_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
